// File: rtl/button_debounce.sv
// button_debounce: cleans up the raw lock-panel push-button for the hold-to-reset stage.
// The pin is optionally inverted (ACTIVE_LOW), passed through a two-flop synchroniser,
// and qualified by a four-state FSM. A new level is accepted only after the synchronised
// input has stayed put for DEBOUNCE_MS cycles. One cycle is 1 ms on the 1 kHz tick clock.
// A one-cycle btn_press pulse accompanies every accepted press.
// Optional macro BTN_RELEASE_PULSE_EN adds the btn_release port. It pulses for one cycle
// on the same edge that btn_level falls.
// DEBOUNCE_MS is meaningful in the range 1..1000.

module button_debounce #(
    parameter int DEBOUNCE_MS = 20,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic btn_release
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic INVERT = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_i;
    logic             sync_q1;
    logic             sync_q2;

    // Normalise polarity first, so that everything downstream reads 1 as pressed.
    assign btn_i = btn_raw ^ INVERT;

    // Two-flop synchroniser for the asynchronous pin. Both flops clear to the not-pressed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
        end
    end

    // Qualification FSM. It sets the registered level and produces single-cycle pulses
    // that drop on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            btn_release <= 1'b0;
`endif
        end else begin
            btn_press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            btn_release <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sync_q2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_q2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                        btn_release <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed, table-driven bench for button_debounce with DEBOUNCE_MS=4.
// The main instance is active-high. A second instance with ACTIVE_LOW=1 shares clock and reset.
// Release-pulse checks are compiled in only when BTN_RELEASE_PULSE_EN is defined.

module tb_button_debounce;

    localparam int DB = 4;

    typedef struct {
        logic rst;
        logic raw;
        logic exp_level;
        logic exp_press;
        logic exp_release;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_raw_al = 1'b1;
    logic btn_level, btn_press;
    logic al_level, al_press;
`ifdef BTN_RELEASE_PULSE_EN
    logic btn_release, al_release;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vecs[$];

    button_debounce #(.DEBOUNCE_MS(DB), .ACTIVE_LOW(0)) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press)
`ifdef BTN_RELEASE_PULSE_EN
        ,
        .btn_release(btn_release)
`endif
    );

    button_debounce #(.DEBOUNCE_MS(DB), .ACTIVE_LOW(1)) dut_al (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw_al),
        .btn_level(al_level),
        .btn_press(al_press)
`ifdef BTN_RELEASE_PULSE_EN
        ,
        .btn_release(al_release)
`endif
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Drive one cycle's inputs, then let one rising edge pass and settle 1 unit past it.
    task automatic applyStimulus(input logic rst, input logic raw, input logic raw_al);
        reset      = rst;
        btn_raw    = raw;
        btn_raw_al = raw_al;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed bit against its expected value.
    task automatic checkOutput(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Append n copies of a vector to the table.
    task automatic addVec(input int n, input logic rst, input logic raw,
                          input logic lvl, input logic prs, input logic rel);
        vec_t v;
        v.rst = rst;
        v.raw = raw;
        v.exp_level = lvl;
        v.exp_press = prs;
        v.exp_release = rel;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Fill the vector table, apply it, then run the hand-written multi-cycle sequences.
    initial begin
        // Reset for 3 cycles, then idle low for 10 cycles.
        addVec(3, 1, 0, 0, 0, 0);
        addVec(10, 0, 0, 0, 0, 0);
        // Clean press: level and pulse rise after the 7th sampled 1 (E0+6).
        addVec(6, 0, 1, 0, 0, 0);
        addVec(1, 0, 1, 1, 1, 0);
        addVec(6, 0, 1, 1, 0, 0);
        // Glitch release: 3 low samples, then back high. No release is accepted.
        addVec(3, 0, 0, 1, 0, 0);
        addVec(4, 0, 1, 1, 0, 0);
        // Real release: level falls with a release pulse at R0+6.
        addVec(6, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 0, 0, 1);
        addVec(3, 0, 0, 0, 0, 0);
        // Bounce 1,0,1,1,0, then a steady 1. One press fires 6 cycles after the final stable 1.
        addVec(1, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(2, 0, 1, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(6, 0, 1, 0, 0, 0);
        addVec(1, 0, 1, 1, 1, 0);
        addVec(2, 0, 1, 1, 0, 0);
        // Reset while pressed clears the level without emitting any pulse.
        addVec(2, 1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].raw, 1'b1);
            checkOutput($sformatf("vec%0d btn_level", i), btn_level, vecs[i].exp_level);
            checkOutput($sformatf("vec%0d btn_press", i), btn_press, vecs[i].exp_press);
`ifdef BTN_RELEASE_PULSE_EN
            checkOutput($sformatf("vec%0d btn_release", i), btn_release, vecs[i].exp_release);
`endif
        end

        // Reset mid-debounce: after 5 samples of 1 the FSM is in PRESS_WAIT with cnt=3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("mid%0d btn_level", i), btn_level, 1'b0);
            checkOutput($sformatf("mid%0d btn_press", i), btn_press, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("midrst btn_level", btn_level, 1'b0);
        checkOutput("midrst btn_press", btn_press, 1'b0);
        // Button is still held after reset, so a full qualification runs from the first sample.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("post%0d btn_level", i), btn_level, (i >= DB + 2) ? 1'b1 : 1'b0);
            checkOutput($sformatf("post%0d btn_press", i), btn_press, (i == DB + 2) ? 1'b1 : 1'b0);
        end

        // Active-low instance: pin held high so far means not pressed; now pull it low.
        checkOutput("al idle btn_level", al_level, 1'b0);
        checkOutput("al idle btn_press", al_press, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("al%0d btn_level", i), al_level, (i >= DB + 2) ? 1'b1 : 1'b0);
            checkOutput($sformatf("al%0d btn_press", i), al_press, (i == DB + 2) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
